// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port synchronous data memory between two requesters
//   (port 0 = CPU, port 1 = debug/loader). At most one single-beat read or
//   write is accepted per cycle. The memory command is registered, and read
//   data is returned to the port that issued the read.
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   reqN/weN/addrN/wdataN         port N command; held stable until granted
//   gntN                          combinational accept for port N
//   rdataN/rvalidN                port N read return; rvalidN is a 1-cycle pulse
//   mem_we/mem_addr/mem_data      registered memory command
//   mem_in                        memory read data, one cycle after mem_addr
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  rvalid0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  rvalid1,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_in
);

  // Round-robin pointer: 0 = port 0 preferred, 1 = port 1 preferred.
  logic pref_reg;

  logic                  mem_we_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [DATA_WIDTH-1:0] mem_data_reg;

  // First tag stage, aligned with the command currently on the memory bus.
  logic tag_valid_reg;
  logic tag_read_reg;
  logic tag_port_reg;

  logic                  prio1;
  logic                  accept;
  logic                  win;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Port 1 wins a conflict only in round-robin mode when it is preferred.
  assign prio1 = (FIXED_PRIO == 0) && pref_reg;

  // Grants are gated by rst_n so nothing is accepted while reset is held.
  assign gnt0 = rst_n & req0 & ~(req1 & prio1);
  assign gnt1 = rst_n & req1 & ~(req0 & ~prio1);

  assign accept    = gnt0 | gnt1;
  assign win       = gnt1;
  assign sel_we    = win ? we1    : we0;
  assign sel_addr  = win ? addr1  : addr0;
  assign sel_wdata = win ? wdata1 : wdata0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pref_reg      <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_data_reg  <= '0;
      tag_valid_reg <= 1'b0;
      tag_read_reg  <= 1'b0;
      tag_port_reg  <= 1'b0;
    end else begin
      if (accept) begin
        mem_addr_reg <= sel_addr;
        mem_we_reg   <= sel_we;
        if (sel_we) begin
          mem_data_reg <= sel_wdata;
        end
        // The loser of this transfer becomes the preferred port.
        pref_reg <= ~win;
      end else begin
        mem_we_reg <= 1'b0;
      end
      tag_valid_reg <= accept;
      tag_read_reg  <= ~sel_we;
      tag_port_reg  <= win;
    end
  end

  assign mem_we   = mem_we_reg;
  assign mem_addr = mem_addr_reg;
  assign mem_data = mem_data_reg;

  // Per-port return stage. The second tag stage is the rvalid register itself;
  // it lines up with mem_in for the read sampled at the previous edge. While
  // rvalid is high, mem_in is forwarded directly; afterwards the captured copy
  // keeps rdata stable until the port's next read return.
  logic                  rvalid_w [2];
  logic [DATA_WIDTH-1:0] rdata_w  [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ret
      logic                  rvalid_reg;
      logic [DATA_WIDTH-1:0] hold_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rvalid_reg <= 1'b0;
          hold_reg   <= '0;
        end else begin
          rvalid_reg <= tag_valid_reg & tag_read_reg & (tag_port_reg == 1'(gi));
          if (rvalid_reg) begin
            hold_reg <= mem_in;
          end
        end
      end

      assign rvalid_w[gi] = rvalid_reg;
      assign rdata_w[gi]  = rvalid_reg ? mem_in : hold_reg;
    end
  endgenerate

  assign rvalid0 = rvalid_w[0];
  assign rvalid1 = rvalid_w[1];
  assign rdata0  = rdata_w[0];
  assign rdata1  = rdata_w[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Table-driven check of mem_arbiter (round-robin instance) against a
//   synchronous memory model, plus hand-written sequences for mid-flight reset
//   and fixed priority (second instance with FIXED_PRIO=1).
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 6;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Round-robin DUT signals
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_in;

  // Fixed-priority DUT signals
  logic          fp_req0, fp_req1;
  logic          fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1;
  logic [DW-1:0] fp_rdata0, fp_rdata1;
  logic          fp_mem_we;
  logic [AW-1:0] fp_mem_addr;
  logic [DW-1:0] fp_mem_data;
  logic [DW-1:0] fp_mem_in;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_in(mem_in)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(fp_req0), .we0(1'b0), .addr0(6'd0), .wdata0(16'd0),
    .gnt0(fp_gnt0), .rdata0(fp_rdata0), .rvalid0(fp_rvalid0),
    .req1(fp_req1), .we1(1'b0), .addr1(6'd1), .wdata1(16'd0),
    .gnt1(fp_gnt1), .rdata1(fp_rdata1), .rvalid1(fp_rvalid1),
    .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_data(fp_mem_data),
    .mem_in(fp_mem_in)
  );

  assign fp_mem_in = '0;

  // Synchronous single-port memory model, read-first; word i starts as A000+i.
  logic [DW-1:0] mem_model [64];
  logic          mem_init_done;
  always @(posedge clk) begin
    if (mem_init_done !== 1'b1) begin
      for (int i = 0; i < 64; i++) mem_model[i] <= 16'hA000 + 16'(i);
      mem_init_done <= 1'b1;
      mem_in        <= '0;
    end else begin
      if (mem_we) mem_model[mem_addr] <= mem_data;
      mem_in <= mem_model[mem_addr];
    end
  end

  typedef struct {
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          g0, g1, mwe;
    logic [AW-1:0] maddr;
    logic          rv0, rv1;
    logic [DW-1:0] rd0, rd1;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic r0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic r1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                     input logic g0, g1, mwe, input logic [AW-1:0] maddr,
                     input logic rv0, rv1, input logic [DW-1:0] rd0, rd1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.mwe = mwe; v.maddr = maddr;
    v.rv0 = rv0; v.rv1 = rv1; v.rd0 = rd0; v.rd1 = rd1;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    fp_req0 = 0; fp_req1 = 0;
    drive_idle();
    req0 = 1; req1 = 1;  // grants must stay low during reset

    //   r0 w0 a0 d0        r1 w1 a1 d1        g0 g1 we ad rv0 rv1 rd0       rd1
    add(1, 0, 1, 16'h0,    1, 0, 2, 16'h0,    1, 0, 0, 0, 0, 0, 16'h0,    16'h0);
    add(1, 0, 1, 16'h0,    1, 0, 2, 16'h0,    0, 1, 0, 1, 0, 0, 16'h0,    16'h0);
    add(1, 0, 1, 16'h0,    1, 0, 2, 16'h0,    1, 0, 0, 2, 1, 0, 16'hA001, 16'h0);
    add(1, 0, 1, 16'h0,    1, 0, 2, 16'h0,    0, 1, 0, 1, 0, 1, 16'hA001, 16'hA002);
    add(1, 0, 1, 16'h0,    1, 0, 2, 16'h0,    1, 0, 0, 2, 1, 0, 16'hA001, 16'hA002);
    add(1, 0, 1, 16'h0,    1, 0, 2, 16'h0,    0, 1, 0, 1, 0, 1, 16'hA001, 16'hA002);
    add(0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 2, 1, 0, 16'hA001, 16'hA002);
    add(0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 2, 0, 1, 16'hA001, 16'hA002);
    // port 0 write then read of addr 5
    add(1, 1, 5, 16'hBEEF, 0, 0, 0, 16'h0,    1, 0, 0, 2, 0, 0, 16'hA001, 16'hA002);
    add(1, 0, 5, 16'h0,    0, 0, 0, 16'h0,    1, 0, 1, 5, 0, 0, 16'hA001, 16'hA002);
    add(0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 5, 0, 0, 16'hA001, 16'hA002);
    add(0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 5, 1, 0, 16'hBEEF, 16'hA002);
    // port 1 write addr 7, then idle cycles hold mem_addr
    add(0, 0, 0, 16'h0,    1, 1, 7, 16'h5555, 0, 1, 0, 5, 0, 0, 16'hBEEF, 16'hA002);
    add(0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 1, 7, 0, 0, 16'hBEEF, 16'hA002);
    add(0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 7, 0, 0, 16'hBEEF, 16'hA002);
    add(0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 7, 0, 0, 16'hBEEF, 16'hA002);
    // read-after-write across ports (addr 3)
    add(0, 0, 0, 16'h0,    1, 1, 3, 16'h1234, 0, 1, 0, 7, 0, 0, 16'hBEEF, 16'hA002);
    add(1, 0, 3, 16'h0,    0, 0, 0, 16'h0,    1, 0, 1, 3, 0, 0, 16'hBEEF, 16'hA002);
    add(0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 3, 0, 0, 16'hBEEF, 16'hA002);
    add(0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 3, 1, 0, 16'h1234, 16'hA002);
    // conflict lost by port 0, which then withdraws its read of addr 4
    add(1, 0, 4, 16'h0,    1, 1, 6, 16'hFFFF, 0, 1, 0, 3, 0, 0, 16'h1234, 16'hA002);
    add(0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 1, 6, 0, 0, 16'h1234, 16'hA002);
    add(1, 0, 6, 16'h0,    0, 0, 0, 16'h0,    1, 0, 0, 6, 0, 0, 16'h1234, 16'hA002);
    add(0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 6, 0, 0, 16'h1234, 16'hA002);
    add(0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 6, 1, 0, 16'hFFFF, 16'hA002);
    add(0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 6, 0, 0, 16'hFFFF, 16'hA002);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_gnt0", 0, 32'(gnt0), 32'd0);
    check("reset_gnt1", 0, 32'(gnt1), 32'd0);
    check("reset_mem_we", 0, 32'(mem_we), 32'd0);
    check("reset_mem_addr", 0, 32'(mem_addr), 32'd0);
    check("reset_mem_data", 0, 32'(mem_data), 32'd0);
    check("reset_rvalid", 0, 32'({rvalid0, rvalid1}), 32'd0);
    check("reset_rdata", 0, {rdata0, rdata1}, 32'd0);
    drive_idle();
    rst_n = 1'b1;

    // Table-driven vectors, one per cycle
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      req0 = vecs[i].r0; we0 = vecs[i].w0; addr0 = vecs[i].a0; wdata0 = vecs[i].d0;
      req1 = vecs[i].r1; we1 = vecs[i].w1; addr1 = vecs[i].a1; wdata1 = vecs[i].d1;
      @(negedge clk);
      check("gnt0", i, 32'(gnt0), 32'(vecs[i].g0));
      check("gnt1", i, 32'(gnt1), 32'(vecs[i].g1));
      check("mem_we", i, 32'(mem_we), 32'(vecs[i].mwe));
      check("mem_addr", i, 32'(mem_addr), 32'(vecs[i].maddr));
      check("rvalid0", i, 32'(rvalid0), 32'(vecs[i].rv0));
      check("rvalid1", i, 32'(rvalid1), 32'(vecs[i].rv1));
      check("rdata0", i, 32'(rdata0), 32'(vecs[i].rd0));
      check("rdata1", i, 32'(rdata1), 32'(vecs[i].rd1));
      $display("[TB] vec %0d: gnt=%b%b mem_we=%b mem_addr=%0d rvalid=%b%b rdata0=%h rdata1=%h",
               i, gnt0, gnt1, mem_we, mem_addr, rvalid0, rvalid1, rdata0, rdata1);
    end

    // Reset mid-flight: accept a read of addr 1, then reset while its tag is in flight
    @(posedge clk); #1;
    drive_idle();
    req0 = 1; addr0 = 1;
    @(negedge clk);
    check("rst_seq_gnt0", 0, 32'(gnt0), 32'd1);
    @(posedge clk); #1;
    req1 = 1; addr1 = 2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_gnt", 1, 32'({gnt0, gnt1}), 32'd0);
    check("rst_mid_mem_we", 1, 32'(mem_we), 32'd0);
    check("rst_mid_mem_addr", 1, 32'(mem_addr), 32'd0);
    check("rst_mid_mem_data", 1, 32'(mem_data), 32'd0);
    check("rst_mid_rvalid", 1, 32'({rvalid0, rvalid1}), 32'd0);
    check("rst_mid_rdata", 1, {rdata0, rdata1}, 32'd0);
    $display("[TB] reset mid-flight: mem_addr=%0d rvalid=%b%b", mem_addr, rvalid0, rvalid1);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_rvalid", k, 32'({rvalid0, rvalid1}), 32'd0);
    end
    @(posedge clk); #1;
    req0 = 1; addr0 = 1; req1 = 1; addr1 = 2;
    @(negedge clk);
    check("post_rst_conflict_gnt0", 0, 32'(gnt0), 32'd1);
    check("post_rst_conflict_gnt1", 0, 32'(gnt1), 32'd0);
    $display("[TB] post-reset conflict: gnt=%b%b", gnt0, gnt1);
    @(posedge clk); #1;
    drive_idle();

    // Fixed priority: port 0 wins while it requests, port 1 waits
    fp_req0 = 1; fp_req1 = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("fp_gnt0", k, 32'(fp_gnt0), 32'd1);
      check("fp_gnt1", k, 32'(fp_gnt1), 32'd0);
      $display("[TB] fixed prio cycle %0d: gnt=%b%b", k, fp_gnt0, fp_gnt1);
      @(posedge clk); #1;
    end
    fp_req0 = 0;
    @(negedge clk);
    check("fp_gnt1_after", 4, 32'(fp_gnt1), 32'd1);
    check("fp_gnt0_after", 4, 32'(fp_gnt0), 32'd0);
    $display("[TB] fixed prio release: gnt=%b%b", fp_gnt0, fp_gnt1);
    @(posedge clk); #1;
    fp_req1 = 0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter that shares the single-port synchronous data memory between the CPU (port 0) and a second requester (port 1, debug/loader). It sits between the requesters and the memory instance, on the same divided clock as both. It accepts at most one single-beat read or write per cycle, selects a winner round-robin (or fixed-priority), drives the memory command registered, and returns read data tagged to the issuing port.

Parameters:
ADDR_WIDTH, 6, memory address width
DATA_WIDTH, 16, memory word width
FIXED_PRIO, 0, 0 = round-robin on conflict; 1 = port 0 always wins

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0  in  1  port 0 request; hold with cmd fields stable until accepted
we0  in  1  port 0 write enable (1 = write, 0 = read)
addr0  in  ADDR_WIDTH  port 0 address
wdata0  in  DATA_WIDTH  port 0 write data
gnt0  out  1  port 0 accept, combinational; transfer occurs at an edge where req0 & gnt0
rdata0  out  DATA_WIDTH  port 0 read data, valid when rvalid0
rvalid0  out  1  port 0 read data valid, one-cycle pulse
req1, we1, addr1, wdata1, gnt1, rdata1, rvalid1  same as port 0, for port 1
mem_we  out  1  memory write enable, registered
mem_addr  out  ADDR_WIDTH  memory address, registered
mem_data  out  DATA_WIDTH  memory write data, registered
mem_in  in  DATA_WIDTH  memory read data; valid one cycle after mem_addr is presented

Behaviour:
- Reset (async, rst_n=0): mem_we=0, mem_addr=0, mem_data=0, rvalid0=rvalid1=0, rdata0=rdata1=0, pipeline tags cleared, RR pointer = port 0 preferred. gnt0/gnt1 are 0 while rst_n=0.
- Grant (combinational, same cycle as request):
  - Only one req high: that port is granted.
  - Both high, FIXED_PRIO=1: port 0 granted.
  - Both high, FIXED_PRIO=0: the preferred port is granted.
  - Never both gnt high. gnt_i never high without req_i.
- RR pointer update, only on an accepted transfer: preferred port becomes the non-winner. Unchanged on idle cycles. Under continuous contention the ports strictly alternate.
- Issue, at accept edge E0: mem_addr, mem_we and mem_data are loaded from the winner. mem_we = winner's we. mem_data is loaded only on a write (held otherwise).
- Idle cycle, no accept: mem_we is forced 0. mem_addr and mem_data hold their values.
- Read return:
  - Memory samples mem_addr at E1. mem_in is valid in the cycle after E1.
  - A 2-stage tag pipeline {valid, is_read, port} follows each accept.
  - rvalid_port is asserted in the cycle after E1, i.e. 2 cycles after the acceptance cycle.
  - rdata_port = mem_in, registered into a per-port hold register so rdata stays stable until that port's next read return.
  - Writes produce no rvalid.
- Throughput: one accept per cycle. Back-to-back reads from either or both ports are fully pipelined, with no bubbles.
- Ordering: returns arrive in acceptance order.
- Read-after-write to the same address in consecutive accepts returns the new data, since the memory commits the write at the edge before the read's sample edge.
- Both req high, one granted: the loser keeps req high with fields stable. It is granted in a later cycle: the next cycle under RR, or when req0 drops under FIXED_PRIO=1.
- Requester drops req without a grant: the request is withdrawn and no side effects occur.
- Reset mid-operation: in-flight tags are discarded and no rvalid is emitted after reset. Writes already presented on mem_we before the reset edge are not undone.

Test Plan:
- Single port-0 write then read: req0 we0=1 addr0=5 wdata0=16'hBEEF, accepted; next cycle read addr0=5 -> mem_we=1 for one cycle; rvalid0 pulses 2 cycles after read accept with rdata0=16'hBEEF; rvalid1 stays 0.
- RR contention: both ports hold req and reads to addr 1 and 2 for 6 cycles, FIXED_PRIO=0 -> grants alternate 0,1,0,1,0,1; rvalid sequence matches, each 2 cycles after its accept, no bubbles.
- Fixed priority: FIXED_PRIO=1, req0 high for 4 cycles, req1 high throughout -> gnt1=0 for those 4 cycles; gnt1=1 in the first cycle req0 is low.
- Idle/hold: accept write addr 7, then 3 idle cycles -> mem_we=0 on all idle cycles; mem_addr stays 7; no rvalid.
- Read-after-write across ports: port 1 writes addr 3 = 16'h1234, port 0 reads addr 3 on the next accept -> rvalid0 with rdata0=16'h1234.
- Reset mid-flight: accept a read, assert rst_n=0 one cycle later for 1 cycle -> all outputs zero immediately; no rvalid after release; first post-reset conflict grants port 0.
